// File: rtl/fifo_fwft_stream_adapter.sv
// First-word-fall-through adapter behind a synchronous FIFO read port.
// A head register plus one skid register turn the rd_en/registered-data port into a valid/ready stream.
module fifo_fwft_stream_adapter #(
    parameter int P_DATA_WIDTH = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output logic                    o_fifo_rd_en,
    input  logic [P_DATA_WIDTH-1:0] i_fifo_rdata,
    input  logic                    i_fifo_rempty,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [P_DATA_WIDTH-1:0] o_data,
    output logic [1:0]              o_level
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HEAD  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic                    infl_reg;
    logic [P_DATA_WIDTH-1:0] head_reg, head_next;
    logic [P_DATA_WIDTH-1:0] skid_reg, skid_next;
    logic                    xfer;
    logic [2:0]              commit;

    assign o_valid = (state_reg != ST_EMPTY);
    assign o_data  = head_reg;
    assign o_level = state_reg;
    assign xfer    = o_valid && i_ready;

    // Words held plus the one in flight, minus the one leaving: a new read may only
    // be issued if that total leaves room for it, so the skid can never overflow.
    assign commit       = {1'b0, state_reg} + {2'b00, infl_reg} - {2'b00, xfer};
    assign o_fifo_rd_en = i_rst && !i_fifo_rempty && (commit < 3'd2);

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        case (state_reg)
            ST_EMPTY: begin
                if (infl_reg) begin
                    head_next  = i_fifo_rdata;
                    state_next = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (xfer && infl_reg) begin
                    head_next = i_fifo_rdata;
                end else if (xfer) begin
                    state_next = ST_EMPTY;
                end else if (infl_reg) begin
                    skid_next  = i_fifo_rdata;
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    head_next = skid_reg;
                    if (infl_reg) begin
                        skid_next = i_fifo_rdata;
                    end else begin
                        state_next = ST_HEAD;
                    end
                end
            end
            default: begin
                state_next = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_reg <= ST_EMPTY;
            infl_reg  <= 1'b0;
            head_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            infl_reg  <= o_fifo_rd_en;
            head_reg  <= head_next;
            skid_reg  <= skid_next;
        end
    end

    // With both slots full and no word leaving, no read may be arriving.
    a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_rst)
        !(state_reg == ST_FULL && infl_reg && !xfer));

endmodule

// File: tb/tb_fifo_fwft_stream_adapter.sv
// Randomized bench for fifo_fwft_stream_adapter: a queue-based FIFO feeds the DUT and a
// queue model of the local buffer predicts valid/data/level/rd_en every cycle.
module tb_fifo_fwft_stream_adapter;

    logic       clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       o_fifo_rd_en;
    logic [3:0] i_fifo_rdata = 4'd0;
    logic       i_fifo_rempty = 1'b1;
    logic       o_valid;
    logic       i_ready = 1'b0;
    logic [3:0] o_data;
    logic [1:0] o_level;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Environment and reference model state
    logic [3:0] fifo_q[$];
    logic [3:0] buf_q[$];
    logic       infl_m = 1'b0;
    logic [3:0] infl_d = 4'd0;
    int         wr_val = 0;
    logic [3:0] exp_next = 4'd0;
    logic       model_ok = 1'b0;
    logic       after_rst = 1'b0;

    always #5 clk = ~clk;

    fifo_fwft_stream_adapter #(.P_DATA_WIDTH(4)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .o_fifo_rd_en (o_fifo_rd_en),
        .i_fifo_rdata (i_fifo_rdata),
        .i_fifo_rempty(i_fifo_rempty),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_level      (o_level)
    );

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check outputs, advance FIFO and model, then write nwr words.
    task automatic cycle(input logic rst_n, input logic rdy, input int nwr);
        logic exp_xfer, exp_rd, dut_rd;
        int   pending;
        @(negedge clk);
        i_rst         = rst_n;
        i_ready       = rdy;
        i_fifo_rempty = (fifo_q.size() == 0);
        #1;
        exp_xfer = (buf_q.size() > 0) && rdy;
        pending  = buf_q.size() + int'(infl_m) - int'(exp_xfer);
        exp_rd   = rst_n && !i_fifo_rempty && (pending < 2);
        dut_rd   = o_fifo_rd_en;
        check_value("rd_en", 32'(o_fifo_rd_en), 32'(exp_rd));
        if (model_ok) begin
            check_value("valid", 32'(o_valid), 32'(buf_q.size() > 0));
            check_value("level", 32'(o_level), 32'(buf_q.size()));
            if (buf_q.size() > 0)
                check_value("data", 32'(o_data), 32'(buf_q[0]));
            else if (after_rst)
                check_value("rst_data", 32'(o_data), 32'd0);
            if (o_valid && rdy) begin
                check_value("order", 32'(o_data), 32'(exp_next));
                exp_next = exp_next + 4'd1;
            end
        end
        @(posedge clk);
        #1;
        if (dut_rd && fifo_q.size() > 0)
            i_fifo_rdata = fifo_q.pop_front();
        if (!rst_n) begin
            buf_q.delete();
            infl_m    = 1'b0;
            model_ok  = 1'b1;
            after_rst = 1'b1;
            exp_next  = (fifo_q.size() > 0) ? fifo_q[0] : 4'(wr_val);
        end else begin
            if (exp_xfer)
                void'(buf_q.pop_front());
            if (infl_m)
                buf_q.push_back(infl_d);
            infl_m    = exp_rd;
            infl_d    = i_fifo_rdata;
            after_rst = 1'b0;
        end
        repeat (nwr) begin
            fifo_q.push_back(4'(wr_val));
            wr_val++;
        end
    endtask

    // Restart the word sequence; only used once everything has drained.
    task automatic restart_seq(input int v);
        wr_val   = v;
        exp_next = 4'(v);
    endtask

    initial begin
        logic rdy;
        int   bias;
        // Reset held for 3 cycles with the FIFO non-empty
        restart_seq(9);
        cycle(1'b0, 1'b1, 2);
        cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 0);
        repeat (6) cycle(1'b1, 1'b1, 0);

        // Streaming 1..4 with ready held high
        restart_seq(1);
        cycle(1'b1, 1'b1, 4);
        repeat (8) cycle(1'b1, 1'b1, 0);

        // Stall with 5 words, then release
        restart_seq(1);
        cycle(1'b1, 1'b0, 5);
        repeat (6) cycle(1'b1, 1'b0, 0);
        check_value("stall_level", 32'(o_level), 32'd2);
        check_value("stall_data", 32'(o_data), 32'd1);
        repeat (9) cycle(1'b1, 1'b1, 0);

        // Alternating ready over 16 words
        restart_seq(0);
        cycle(1'b1, 1'b1, 16);
        for (int i = 0; i < 40; i++) cycle(1'b1, 1'(i % 2), 0);

        // Drain mid-burst, then a late write
        cycle(1'b1, 1'b1, 3);
        repeat (6) cycle(1'b1, 1'b1, 0);
        cycle(1'b1, 1'b1, 2);
        repeat (5) cycle(1'b1, 1'b1, 0);

        // Reset with level 2, then reset with a read in flight
        cycle(1'b1, 1'b0, 6);
        repeat (4) cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
        repeat (10) cycle(1'b1, 1'b1, 0);
        cycle(1'b1, 1'b1, 4);
        cycle(1'b1, 1'b1, 0);
        cycle(1'b0, 1'b1, 0);
        repeat (10) cycle(1'b1, 1'b1, 0);

        // Random traffic with varying backpressure and occasional resets
        for (int seg = 0; seg < 6; seg++) begin
            bias = 20 + seg * 15;
            for (int i = 0; i < 500; i++) begin
                rdy = ($urandom_range(0, 99) < bias);
                cycle(($urandom_range(0, 99) != 0), rdy,
                      (fifo_q.size() < 8) ? int'($urandom_range(0, 2)) : 0);
            end
        end
        repeat (12) cycle(1'b1, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
